fft64_frame_ctrl: RTL and testbench

Frame sequencer and flow controller for the 64-point FFT pipeline with its output reorder stage.
- Accepts a ready/valid complex sample stream and cuts it into contiguous 64-sample frames.
- Drives the pipeline's global clock-enable from downstream backpressure.
- Tags each 32-beat output frame (two bins per beat) with first/last markers.
- Tracks frames in flight and flags protocol errors.

---
 rtl/fft64_frame_ctrl_if.sv | 61 ++++++
 rtl/fft64_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fft64_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft64_frame_ctrl_if.sv
// Bus bundle between the frame controller and its surroundings.
// It carries the input stream, the pipeline side, the output stream and the status signals.
interface fft64_frame_ctrl_if #(
  parameter int width = 11,
  parameter int cnt_w = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [width-1:0] s_re;
  logic [width-1:0] s_im;

  logic             fft_ce;
  logic             fft_valid_a;
  logic [width-1:0] fft_ar;
  logic [width-1:0] fft_ai;
  logic             fft_valid_o;
  logic [width-1:0] fft_xr;
  logic [width-1:0] fft_xi;
  logic [width-1:0] fft_yr;
  logic [width-1:0] fft_yi;

  logic             m_valid;
  logic             m_ready;
  logic [width-1:0] m_xr;
  logic [width-1:0] m_xi;
  logic [width-1:0] m_yr;
  logic [width-1:0] m_yi;
  logic             m_first;
  logic             m_last;
  logic [4:0]       m_beat;

  logic             busy;
  logic [cnt_w-1:0] frames_in;
  logic [cnt_w-1:0] frames_out;
  logic             err_underrun;
  logic             err_spurious;
  logic             clear_err;

  // The frame controller owns this bus.
  modport master (
    input  s_valid, s_re, s_im,
    output s_ready,
    output fft_ce, fft_valid_a, fft_ar, fft_ai,
    input  fft_valid_o, fft_xr, fft_xi, fft_yr, fft_yi,
    output m_valid, m_xr, m_xi, m_yr, m_yi, m_first, m_last, m_beat,
    input  m_ready,
    output busy, frames_in, frames_out, err_underrun, err_spurious,
    input  clear_err
  );

  modport slave (
    output s_valid, s_re, s_im,
    input  s_ready,
    input  fft_ce, fft_valid_a, fft_ar, fft_ai,
    output fft_valid_o, fft_xr, fft_xi, fft_yr, fft_yi,
    input  m_valid, m_xr, m_xi, m_yr, m_yi, m_first, m_last, m_beat,
    output m_ready,
    input  busy, frames_in, frames_out, err_underrun, err_spurious,
    output clear_err
  );
endinterface

// File: rtl/fft64_frame_ctrl.sv
// Frame sequencer for the 64-point FFT: cuts the input stream into 64-sample frames,
// gates the pipeline clock-enable on output backpressure and tags 32-beat output frames.
module fft64_frame_ctrl #(
  parameter int width      = 11,
  parameter int max_frames = 4,
  parameter int cnt_w      = 16
) (
  input logic               CLK,
  input logic               RST,
  fft64_frame_ctrl_if.master bus
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [3:0] max_out = 4'(max_frames);

  state_t           state;
  state_t           state_next;
  logic [5:0]       samp_cnt;
  logic [5:0]       samp_cnt_next;
  logic [4:0]       beat_cnt;
  logic [3:0]       outstanding;
  logic [cnt_w-1:0] frames_in_q;
  logic [cnt_w-1:0] frames_out_q;
  logic             err_underrun_q;
  logic             err_spurious_q;
  logic             valid_a_q;
  logic [width-1:0] ar_q;
  logic [width-1:0] ai_q;

  logic have_frames;
  logic stall;
  logic ce;
  logic s_ready_c;
  logic emit;
  logic pad;
  logic in_done;
  logic out_hs;
  logic out_done;
  logic spurious;

  // Output only stalls while a real frame is draining; stray pipeline beats never block.
  assign have_frames = (outstanding != 4'd0);
  assign stall       = bus.fft_valid_o & ~bus.m_ready & have_frames;
  assign ce          = RST & ~stall;
  assign out_hs      = bus.m_valid & bus.m_ready;
  assign out_done    = out_hs & (beat_cnt == 5'd31);
  assign spurious    = bus.fft_valid_o & ~have_frames;

  assign bus.fft_ce      = ce;
  assign bus.s_ready     = s_ready_c;
  assign bus.fft_valid_a = valid_a_q;
  assign bus.fft_ar      = ar_q;
  assign bus.fft_ai      = ai_q;

  assign bus.m_valid = bus.fft_valid_o & have_frames & RST;
  assign bus.m_xr    = bus.fft_xr;
  assign bus.m_xi    = bus.fft_xi;
  assign bus.m_yr    = bus.fft_yr;
  assign bus.m_yi    = bus.fft_yi;
  assign bus.m_beat  = beat_cnt;
  assign bus.m_first = (beat_cnt == 5'd0);
  assign bus.m_last  = (beat_cnt == 5'd31);

  assign bus.busy         = (state == FILL) | have_frames;
  assign bus.frames_in    = frames_in_q;
  assign bus.frames_out   = frames_out_q;
  assign bus.err_underrun = err_underrun_q;
  assign bus.err_spurious = err_spurious_q;

  always_comb begin
    state_next    = state;
    samp_cnt_next = samp_cnt;
    s_ready_c     = 1'b0;
    emit          = 1'b0;
    pad           = 1'b0;
    in_done       = 1'b0;
    case (state)
      IDLE: begin
        s_ready_c = ce & (outstanding < max_out);
        emit      = bus.s_valid & s_ready_c;
        if (emit) begin
          state_next    = FILL;
          samp_cnt_next = 6'd1;
        end
      end
      FILL: begin
        // Once a frame has started it must stay contiguous, so gaps become zero samples.
        s_ready_c = ce;
        emit      = ce;
        pad       = ce & ~bus.s_valid;
        if (ce) begin
          samp_cnt_next = samp_cnt + 6'd1;
          if (samp_cnt == 6'd63) begin
            in_done    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        samp_cnt_next = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= IDLE;
      samp_cnt       <= 6'd0;
      beat_cnt       <= 5'd0;
      outstanding    <= 4'd0;
      frames_in_q    <= '0;
      frames_out_q   <= '0;
      err_underrun_q <= 1'b0;
      err_spurious_q <= 1'b0;
      valid_a_q      <= 1'b0;
      ar_q           <= '0;
      ai_q           <= '0;
    end else begin
      if (ce) begin
        state     <= state_next;
        samp_cnt  <= samp_cnt_next;
        valid_a_q <= emit;
        if (emit) begin
          ar_q <= pad ? '0 : bus.s_re;
          ai_q <= pad ? '0 : bus.s_im;
        end
        if (out_hs) begin
          beat_cnt <= beat_cnt + 5'd1;
        end
        if (in_done) begin
          frames_in_q <= frames_in_q + cnt_w'(1);
        end
        if (out_done) begin
          frames_out_q <= frames_out_q + cnt_w'(1);
        end
        // A frame finishing on each side in the same cycle leaves the count alone.
        case ({in_done, out_done})
          2'b10:   outstanding <= outstanding + 4'd1;
          2'b01:   outstanding <= outstanding - 4'd1;
          default: outstanding <= outstanding;
        endcase
      end
      if (bus.clear_err) begin
        err_underrun_q <= 1'b0;
        err_spurious_q <= 1'b0;
      end else if (ce) begin
        if (pad) begin
          err_underrun_q <= 1'b1;
        end
        if (spurious) begin
          err_spurious_q <= 1'b1;
        end
      end
    end
  end

  a_outstanding_max: assert property (@(posedge CLK) disable iff (!RST)
    outstanding <= max_out);

  a_idle_count_zero: assert property (@(posedge CLK) disable iff (!RST)
    (state == IDLE) |-> (samp_cnt == 6'd0));

endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// Directed bench for fft64_frame_ctrl: framing, padding, backpressure, frame limit,
// stray pipeline output and reset in mid-frame / mid-output.
module tb_fft64_frame_ctrl;

  localparam int W  = 11;
  localparam int CW = 16;

  logic CLK;
  logic RST;
  int   vec_count;
  int   miscompares;

  fft64_frame_ctrl_if #(.width(W), .cnt_w(CW)) bus ();

  fft64_frame_ctrl #(.width(W), .max_frames(4), .cnt_w(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge CLK);
    bus.s_valid = v;
    bus.s_re    = re;
    bus.s_im    = im;
  endtask

  task automatic check_emission(input logic was_pad, input logic [W-1:0] n);
    logic [W-1:0] neg;
    neg = -n;
    checkOutput("fft_valid_a", 32'(bus.fft_valid_a), 1);
    checkOutput("fft_ar", 32'(bus.fft_ar), was_pad ? 32'd0 : 32'(n));
    checkOutput("fft_ai", 32'(bus.fft_ai), was_pad ? 32'd0 : 32'(neg));
  endtask

  // Feeds len emission cycles; cycles [gap_at, gap_at+gap_len) drop s_valid.
  task automatic fill_frame(input int len, input int gap_at, input int gap_len);
    int           n;
    logic         pad;
    logic         prev_pad;
    logic [W-1:0] prev_n;
    logic [W-1:0] nv;
    n        = 0;
    prev_pad = 1'b0;
    prev_n   = '0;
    for (int c = 0; c < len; c++) begin
      pad = (c >= gap_at) && (c < gap_at + gap_len);
      @(negedge CLK);
      if (c > 0) check_emission(prev_pad, prev_n);
      nv          = W'(n);
      bus.s_valid = !pad;
      bus.s_re    = nv;
      bus.s_im    = -nv;
      #1;
      if (!pad) checkOutput("s_ready", 32'(bus.s_ready), 1);
      prev_pad = pad;
      prev_n   = nv;
      if (!pad) n++;
    end
    @(negedge CLK);
    check_emission(prev_pad, prev_n);
    bus.s_valid = 1'b0;
  endtask

  // Presents n_beats pipeline outputs; beat stall_beat is held off for two cycles first.
  task automatic drain_frame(input int n_beats, input int stall_beat);
    for (int b = 0; b < n_beats; b++) begin
      @(negedge CLK);
      bus.fft_valid_o = 1'b1;
      bus.fft_xr      = W'(b);
      bus.fft_xi      = W'(b + 64);
      bus.fft_yr      = W'(b + 128);
      bus.fft_yi      = W'(b + 256);
      bus.m_ready     = (b != stall_beat);
      if (b == stall_beat) begin
        for (int s = 0; s < 2; s++) begin
          #1;
          checkOutput("stall_ce", 32'(bus.fft_ce), 0);
          checkOutput("stall_s_ready", 32'(bus.s_ready), 0);
          checkOutput("stall_m_beat", 32'(bus.m_beat), 32'(b));
          checkOutput("stall_m_xr", 32'(bus.m_xr), 32'(b));
          @(negedge CLK);
        end
        bus.m_ready = 1'b1;
      end
      #1;
      checkOutput("m_valid", 32'(bus.m_valid), 1);
      checkOutput("m_beat", 32'(bus.m_beat), 32'(b));
      checkOutput("m_first", 32'(bus.m_first), 32'(b == 0));
      checkOutput("m_last", 32'(bus.m_last), 32'(b == 31));
      checkOutput("m_xr", 32'(bus.m_xr), 32'(b));
      checkOutput("m_yi", 32'(bus.m_yi), 32'(b + 256));
    end
  endtask

  initial begin
    vec_count       = 0;
    miscompares     = 0;
    RST             = 1'b0;
    bus.s_valid     = 1'b1;
    bus.s_re        = '0;
    bus.s_im        = '0;
    bus.fft_valid_o = 1'b1;
    bus.fft_xr      = '0;
    bus.fft_xi      = '0;
    bus.fft_yr      = '0;
    bus.fft_yi      = '0;
    bus.m_ready     = 1'b1;
    bus.clear_err   = 1'b0;

    // Reset with live inputs: everything must stay quiet.
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("rst_fft_ce", 32'(bus.fft_ce), 0);
    checkOutput("rst_s_ready", 32'(bus.s_ready), 0);
    checkOutput("rst_m_valid", 32'(bus.m_valid), 0);
    @(negedge CLK);
    RST             = 1'b1;
    bus.s_valid     = 1'b0;
    bus.fft_valid_o = 1'b0;
    #1;
    checkOutput("init_fft_ce", 32'(bus.fft_ce), 1);
    checkOutput("init_s_ready", 32'(bus.s_ready), 1);
    checkOutput("init_frames_in", 32'(bus.frames_in), 0);
    checkOutput("init_frames_out", 32'(bus.frames_out), 0);
    checkOutput("init_busy", 32'(bus.busy), 0);
    checkOutput("init_valid_a", 32'(bus.fft_valid_a), 0);
    checkOutput("init_err_u", 32'(bus.err_underrun), 0);
    checkOutput("init_err_s", 32'(bus.err_spurious), 0);
    checkOutput("init_m_first", 32'(bus.m_first), 1);

    // One clean frame in, one 32-beat frame out.
    fill_frame(64, -1, 0);
    checkOutput("f1_frames_in", 32'(bus.frames_in), 1);
    checkOutput("f1_busy", 32'(bus.busy), 1);
    @(negedge CLK);
    checkOutput("f1_valid_a_end", 32'(bus.fft_valid_a), 0);
    drain_frame(32, -1);
    @(negedge CLK);
    bus.fft_valid_o = 1'b0;
    #1;
    checkOutput("f1_m_valid_end", 32'(bus.m_valid), 0);
    checkOutput("f1_frames_out", 32'(bus.frames_out), 1);
    checkOutput("f1_busy_end", 32'(bus.busy), 0);

    // Three-cycle input gap at sample 20 is padded.
    fill_frame(64, 20, 3);
    checkOutput("gap_frames_in", 32'(bus.frames_in), 2);
    checkOutput("gap_err_u", 32'(bus.err_underrun), 1);
    @(negedge CLK);
    bus.clear_err = 1'b1;
    @(negedge CLK);
    bus.clear_err = 1'b0;
    checkOutput("gap_err_u_clr", 32'(bus.err_underrun), 0);

    // Backpressure on output beat 5.
    drain_frame(32, 5);
    @(negedge CLK);
    bus.fft_valid_o = 1'b0;
    #1;
    checkOutput("bp_frames_out", 32'(bus.frames_out), 2);
    checkOutput("bp_busy", 32'(bus.busy), 0);

    // Stray pipeline output with nothing in flight.
    @(negedge CLK);
    bus.fft_valid_o = 1'b1;
    #1;
    checkOutput("sp_m_valid", 32'(bus.m_valid), 0);
    checkOutput("sp_fft_ce", 32'(bus.fft_ce), 1);
    @(negedge CLK);
    bus.fft_valid_o = 1'b0;
    checkOutput("sp_err_s", 32'(bus.err_spurious), 1);
    checkOutput("sp_m_beat", 32'(bus.m_beat), 0);
    checkOutput("sp_frames_out", 32'(bus.frames_out), 2);
    @(negedge CLK);
    bus.fft_valid_o = 1'b1;
    bus.clear_err   = 1'b1;
    @(negedge CLK);
    bus.fft_valid_o = 1'b0;
    bus.clear_err   = 1'b0;
    checkOutput("sp_clear_wins", 32'(bus.err_spurious), 0);

    // Frame limit: four frames fill, the fifth is held off.
    bus.m_ready = 1'b0;
    repeat (264) applyStimulus(1'b1, W'(5), W'(5));
    @(negedge CLK);
    #1;
    checkOutput("lim_s_ready", 32'(bus.s_ready), 0);
    checkOutput("lim_frames_in", 32'(bus.frames_in), 6);
    checkOutput("lim_busy", 32'(bus.busy), 1);
    checkOutput("lim_valid_a", 32'(bus.fft_valid_a), 0);
    drain_frame(32, -1);
    drain_frame(32, -1);
    drain_frame(32, -1);
    @(posedge CLK);
    #1;
    checkOutput("lim_frames_in_5", 32'(bus.frames_in), 7);
    checkOutput("lim_frames_out_3", 32'(bus.frames_out), 5);
    drain_frame(32, -1);
    drain_frame(32, -1);
    @(posedge CLK);
    #1;
    bus.s_valid = 1'b0;
    checkOutput("lim_frames_in_6", 32'(bus.frames_in), 8);
    checkOutput("lim_frames_out_5", 32'(bus.frames_out), 7);
    drain_frame(32, -1);
    @(negedge CLK);
    bus.fft_valid_o = 1'b0;
    #1;
    checkOutput("lim_frames_out_6", 32'(bus.frames_out), 8);
    checkOutput("lim_busy_end", 32'(bus.busy), 0);

    // Reset in the middle of an input frame.
    fill_frame(30, 10, 1);
    checkOutput("rf_err_u", 32'(bus.err_underrun), 1);
    RST             = 1'b0;
    bus.s_valid     = 1'b1;
    bus.fft_valid_o = 1'b1;
    #1;
    checkOutput("rf_fft_ce", 32'(bus.fft_ce), 0);
    checkOutput("rf_s_ready", 32'(bus.s_ready), 0);
    checkOutput("rf_m_valid", 32'(bus.m_valid), 0);
    @(negedge CLK);
    checkOutput("rf_frames_in", 32'(bus.frames_in), 0);
    checkOutput("rf_frames_out", 32'(bus.frames_out), 0);
    checkOutput("rf_busy", 32'(bus.busy), 0);
    checkOutput("rf_err_u_clr", 32'(bus.err_underrun), 0);
    checkOutput("rf_valid_a", 32'(bus.fft_valid_a), 0);
    RST             = 1'b1;
    bus.s_valid     = 1'b0;
    bus.fft_valid_o = 1'b0;

    // Reset in the middle of an output frame.
    fill_frame(64, -1, 0);
    checkOutput("ro_frames_in", 32'(bus.frames_in), 1);
    drain_frame(10, -1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("ro_fft_ce", 32'(bus.fft_ce), 0);
    checkOutput("ro_m_valid", 32'(bus.m_valid), 0);
    checkOutput("ro_m_beat_pre", 32'(bus.m_beat), 10);
    @(negedge CLK);
    checkOutput("ro_frames_in", 32'(bus.frames_in), 0);
    checkOutput("ro_m_beat", 32'(bus.m_beat), 0);
    checkOutput("ro_busy", 32'(bus.busy), 0);
    RST             = 1'b1;
    bus.fft_valid_o = 1'b0;

    // Fresh frame after reset behaves normally.
    fill_frame(64, -1, 0);
    checkOutput("fr_frames_in", 32'(bus.frames_in), 1);
    drain_frame(32, -1);
    @(negedge CLK);
    bus.fft_valid_o = 1'b0;
    #1;
    checkOutput("fr_frames_out", 32'(bus.frames_out), 1);
    checkOutput("fr_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
